// File: rtl/localbus_arbiter.sv
// -----------------------------------------------------------------------------
// localbus_arbiter
//
// Shares the single data-memory port of localbus between two masters:
//   master 0 : top_core load/store port
//   master 1 : secondary master (debug loader / DMA)
// At most one single-beat transfer is granted per cycle. The granted master's
// payload is steered combinationally to the slave. Read results are routed
// back to the issuing master through a tag pipeline whose depth matches the
// slave read latency.
//
// Parameters
//   XLEN       data / address width
//   RD_LAT     slave read latency in cycles (1..4)
//   STARVE_MAX consecutive lost cycles before master 1 is forced to win (1..255)
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   mX_req/addr/wdata/we      master X request and payload (we==0 is a read)
//   mX_gnt                    master X transfer accepted this cycle
//   mX_rvalid/rdata           master X read return (rdata is s_qout for both)
//   m1_lock                   master 1 asks for exclusive ownership
//   s_addr/s_wdata/s_we       slave drive, all zero when nothing is granted
//   s_qout                    slave read data
//
// Build option
//   LOCALBUS_ARB_RR_EN : resolve FREE-state ties round-robin instead of fixed
//                        priority to master 0 with the starvation guard.
// -----------------------------------------------------------------------------
module localbus_arbiter #(
  parameter int XLEN       = 32,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            m0_req,
  input  logic [XLEN-1:0] m0_addr,
  input  logic [XLEN-1:0] m0_wdata,
  input  logic [2:0]      m0_we,
  output logic            m0_gnt,
  output logic            m0_rvalid,
  output logic [XLEN-1:0] m0_rdata,
  input  logic            m1_req,
  input  logic [XLEN-1:0] m1_addr,
  input  logic [XLEN-1:0] m1_wdata,
  input  logic [2:0]      m1_we,
  input  logic            m1_lock,
  output logic            m1_gnt,
  output logic            m1_rvalid,
  output logic [XLEN-1:0] m1_rdata,
  output logic [XLEN-1:0] s_addr,
  output logic [XLEN-1:0] s_wdata,
  output logic [2:0]      s_we,
  input  logic [XLEN-1:0] s_qout
);

  typedef enum logic {
    FREE   = 1'b0,
    LOCKED = 1'b1
  } own_t;

  own_t own;
  logic tie_m1;        // master 1 wins a FREE-state tie this cycle
  logic rd_push;       // a read is accepted by the slave this cycle
  logic [RD_LAT-1:0] rd_vld_p;
  logic [RD_LAT-1:0] rd_own_p;

`ifdef LOCALBUS_ARB_RR_EN
  logic last;          // master granted most recently (resets to 1)

  assign tie_m1 = ~last;
`else
  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

  logic [7:0] starve_cnt;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == STARVE_LIM) ? v : v + 8'd1;
  endfunction

  assign tie_m1 = (starve_cnt == STARVE_LIM);
`endif

  // Grant decision. LOCKED rules only hold while m1_lock stays high; the
  // release cycle is already arbitrated under FREE rules.
  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (!rst) begin
      if (own == LOCKED && m1_lock) begin
        m1_gnt = m1_req;
      end else if (m0_req && m1_req) begin
        m1_gnt = tie_m1;
        m0_gnt = ~tie_m1;
      end else begin
        m0_gnt = m0_req;
        m1_gnt = m1_req;
      end
    end
  end

  // Slave drive: zero when idle so no stray write reaches memory.
  always_comb begin
    s_addr  = '0;
    s_wdata = '0;
    s_we    = '0;
    if (m0_gnt) begin
      s_addr  = m0_addr;
      s_wdata = m0_wdata;
      s_we    = m0_we;
    end else if (m1_gnt) begin
      s_addr  = m1_addr;
      s_wdata = m1_wdata;
      s_we    = m1_we;
    end
  end

  assign rd_push = (m0_gnt && (m0_we == 3'd0)) || (m1_gnt && (m1_we == 3'd0));

  // Control state: ownership, tie-break state, tag valid bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      own      <= FREE;
      rd_vld_p <= '0;
`ifdef LOCALBUS_ARB_RR_EN
      last     <= 1'b1;
`else
      starve_cnt <= 8'd0;
`endif
    end else begin
      if (m1_gnt && m1_lock) begin
        own <= LOCKED;
      end else if (!m1_lock) begin
        own <= FREE;
      end

`ifdef LOCALBUS_ARB_RR_EN
      if (m0_gnt || m1_gnt) begin
        last <= m1_gnt;
      end
`else
      if (m1_gnt || !m1_req) begin
        starve_cnt <= 8'd0;
      end else begin
        starve_cnt <= sat_inc(starve_cnt);
      end
`endif

      // stage 0 boundary: tag captured at grant
      rd_vld_p[0] <= rd_push;
      for (int i = 1; i < RD_LAT; i++) begin
        rd_vld_p[i] <= rd_vld_p[i-1];
      end
    end
  end

  // Owner bits carry no reset; they are only meaningful alongside rd_vld_p.
  always_ff @(posedge clk) begin
    rd_own_p[0] <= m1_gnt;
    for (int i = 1; i < RD_LAT; i++) begin
      rd_own_p[i] <= rd_own_p[i-1];
    end
  end

  // Tail stage: data returns from the slave in this cycle.
  assign m0_rvalid = !rst && rd_vld_p[RD_LAT-1] && !rd_own_p[RD_LAT-1];
  assign m1_rvalid = !rst && rd_vld_p[RD_LAT-1] &&  rd_own_p[RD_LAT-1];
  assign m0_rdata  = s_qout;
  assign m1_rdata  = s_qout;

endmodule

// File: tb/tb_localbus_arbiter.sv
module tb_localbus_arbiter;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            m0_req, m1_req, m1_lock;
  logic [XLEN-1:0] m0_addr, m0_wdata, m1_addr, m1_wdata, s_qout;
  logic [2:0]      m0_we, m1_we;

  // dut1: RD_LAT=1
  logic            a_m0_gnt, a_m0_rvalid, a_m1_gnt, a_m1_rvalid;
  logic [XLEN-1:0] a_m0_rdata, a_m1_rdata, a_s_addr, a_s_wdata;
  logic [2:0]      a_s_we;
  // dut2: RD_LAT=2
  logic            b_m0_gnt, b_m0_rvalid, b_m1_gnt, b_m1_rvalid;
  logic [XLEN-1:0] b_m0_rdata, b_m1_rdata, b_s_addr, b_s_wdata;
  logic [2:0]      b_s_we;

  int checks = 0;
  int errors = 0;

  localbus_arbiter #(.XLEN(XLEN), .RD_LAT(1), .STARVE_MAX(15)) u_dut1 (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_we(m0_we),
    .m0_gnt(a_m0_gnt), .m0_rvalid(a_m0_rvalid), .m0_rdata(a_m0_rdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_we(m1_we),
    .m1_lock(m1_lock),
    .m1_gnt(a_m1_gnt), .m1_rvalid(a_m1_rvalid), .m1_rdata(a_m1_rdata),
    .s_addr(a_s_addr), .s_wdata(a_s_wdata), .s_we(a_s_we), .s_qout(s_qout)
  );

  localbus_arbiter #(.XLEN(XLEN), .RD_LAT(2), .STARVE_MAX(15)) u_dut2 (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_we(m0_we),
    .m0_gnt(b_m0_gnt), .m0_rvalid(b_m0_rvalid), .m0_rdata(b_m0_rdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_we(m1_we),
    .m1_lock(m1_lock),
    .m1_gnt(b_m1_gnt), .m1_rvalid(b_m1_rvalid), .m1_rdata(b_m1_rdata),
    .s_addr(b_s_addr), .s_wdata(b_s_wdata), .s_we(b_s_we), .s_qout(s_qout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Outputs are sampled at the falling edge.
  task automatic settle();
    #4;
  endtask

  task automatic drv_m0(input logic req, input logic [XLEN-1:0] addr,
                        input logic [XLEN-1:0] wdata, input logic [2:0] we);
    m0_req = req; m0_addr = addr; m0_wdata = wdata; m0_we = we;
  endtask

  task automatic drv_m1(input logic req, input logic [XLEN-1:0] addr,
                        input logic [XLEN-1:0] wdata, input logic [2:0] we,
                        input logic lock);
    m1_req = req; m1_addr = addr; m1_wdata = wdata; m1_we = we; m1_lock = lock;
  endtask

  task automatic idle();
    drv_m0(1'b0, '0, '0, 3'd0);
    drv_m1(1'b0, '0, '0, 3'd0, 1'b0);
  endtask

  task automatic rst_pulse();
    tick();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic exp_m1;
    rst = 1'b1;
    s_qout = '0;
    // ---------------- reset with requests pending ----------------
    drv_m0(1'b1, 32'h44, 32'h55, 3'b001);
    drv_m1(1'b1, 32'h48, 32'h66, 3'b010, 1'b1);
    tick();
    settle();
    chk("rst_m0_gnt", 32'(a_m0_gnt), 32'd0);
    chk("rst_m1_gnt", 32'(a_m1_gnt), 32'd0);
    chk("rst_s_we", 32'(a_s_we), 32'd0);
    chk("rst_m0_rvalid", 32'(a_m0_rvalid), 32'd0);
    chk("rst_m1_rvalid", 32'(a_m1_rvalid), 32'd0);
    tick();
    idle();
    rst = 1'b0;
    settle();
    chk("idle_s_we", 32'(a_s_we), 32'd0);
    chk("idle_s_addr", a_s_addr, 32'd0);

    // ---------------- single read from m0 ----------------
    tick();
    drv_m0(1'b1, 32'h100, 32'h0, 3'd0);
    settle();
    chk("rd0_gnt", 32'(a_m0_gnt), 32'd1);
    chk("rd0_s_addr", a_s_addr, 32'h100);
    chk("rd0_s_we", 32'(a_s_we), 32'd0);
    tick();
    idle();
    s_qout = 32'hDEADBEEF;
    settle();
    chk("rd0_l1_m0_rvalid", 32'(a_m0_rvalid), 32'd1);
    chk("rd0_l1_m0_rdata", a_m0_rdata, 32'hDEADBEEF);
    chk("rd0_l1_m1_rvalid", 32'(a_m1_rvalid), 32'd0);
    chk("rd0_l2_early", 32'(b_m0_rvalid), 32'd0);
    tick();
    settle();
    chk("rd0_l1_done", 32'(a_m0_rvalid), 32'd0);
    chk("rd0_l2_m0_rvalid", 32'(b_m0_rvalid), 32'd1);
    chk("rd0_l2_m1_rvalid", 32'(b_m1_rvalid), 32'd0);

    // ---------------- tie: m0 write vs m1 read ----------------
    rst_pulse();
    drv_m0(1'b1, 32'h10, 32'h1, 3'b010);
    drv_m1(1'b1, 32'h20, 32'h0, 3'd0, 1'b0);
    settle();
    chk("tie_m0_gnt", 32'(a_m0_gnt), 32'd1);
    chk("tie_m1_gnt", 32'(a_m1_gnt), 32'd0);
    chk("tie_s_we", 32'(a_s_we), 32'b010);
    chk("tie_s_addr", a_s_addr, 32'h10);
    chk("tie_s_wdata", a_s_wdata, 32'h1);
    tick();
    drv_m0(1'b0, '0, '0, 3'd0);
    settle();
    chk("tie_m1_gnt2", 32'(a_m1_gnt), 32'd1);
    chk("tie_s_addr2", a_s_addr, 32'h20);
    chk("tie_m0_rvalid_wr", 32'(a_m0_rvalid), 32'd0);
    tick();
    idle();
    s_qout = 32'hCAFE0001;
    settle();
    chk("tie_m1_rvalid", 32'(a_m1_rvalid), 32'd1);
    chk("tie_m1_rdata", a_m1_rdata, 32'hCAFE0001);
    chk("tie_m0_rvalid", 32'(a_m0_rvalid), 32'd0);

    // ---------------- back-to-back alternating reads ----------------
    tick();
    drv_m0(1'b1, 32'h200, '0, 3'd0);
    settle();
    tick();
    drv_m0(1'b0, '0, '0, 3'd0);
    drv_m1(1'b1, 32'h204, '0, 3'd0, 1'b0);
    settle();
    chk("b2b_c1_m0_rvalid", 32'(a_m0_rvalid), 32'd1);
    chk("b2b_c1_m1_rvalid", 32'(a_m1_rvalid), 32'd0);
    tick();
    drv_m1(1'b0, '0, '0, 3'd0, 1'b0);
    drv_m0(1'b1, 32'h208, '0, 3'd0);
    settle();
    chk("b2b_c2_m1_rvalid", 32'(a_m1_rvalid), 32'd1);
    chk("b2b_c2_m0_rvalid", 32'(a_m0_rvalid), 32'd0);
    chk("b2b_c2_l2_m0", 32'(b_m0_rvalid), 32'd1);
    tick();
    drv_m0(1'b0, '0, '0, 3'd0);
    drv_m1(1'b1, 32'h20C, 32'h9, 3'b100, 1'b0);
    settle();
    chk("b2b_c3_m0_rvalid", 32'(a_m0_rvalid), 32'd1);
    chk("b2b_c3_l2_m1", 32'(b_m1_rvalid), 32'd1);
    tick();
    idle();
    settle();
    chk("b2b_c4_wr_m0", 32'(a_m0_rvalid), 32'd0);
    chk("b2b_c4_wr_m1", 32'(a_m1_rvalid), 32'd0);

    // ---------------- continuous contention ----------------
    rst_pulse();
    for (int k = 1; k <= 17; k++) begin
      drv_m0(1'b1, 32'h300 + 32'(k), 32'(k), 3'b001);
      drv_m1(1'b1, 32'h400 + 32'(k), '0, 3'd0, 1'b0);
      settle();
`ifdef LOCALBUS_ARB_RR_EN
      exp_m1 = (k % 2 == 0);
`else
      exp_m1 = (k == 16);
`endif
      chk($sformatf("cont_k%0d_m1_gnt", k), 32'(a_m1_gnt), 32'(exp_m1));
      chk($sformatf("cont_k%0d_m0_gnt", k), 32'(a_m0_gnt), 32'(!exp_m1));
      tick();
    end
    idle();

    // ---------------- lock ----------------
    rst_pulse();
    drv_m1(1'b1, 32'h500, '0, 3'd0, 1'b1);
    settle();
    chk("lock_first_m1_gnt", 32'(a_m1_gnt), 32'd1);
    for (int j = 1; j <= 3; j++) begin
      tick();
      drv_m0(1'b1, 32'h600, 32'h77, 3'b001);
      drv_m1(1'b1, 32'h500 + 32'(4 * j), '0, 3'd0, 1'b1);
      settle();
      chk($sformatf("lock_rd%0d_m0_gnt", j), 32'(a_m0_gnt), 32'd0);
      chk($sformatf("lock_rd%0d_m1_gnt", j), 32'(a_m1_gnt), 32'd1);
    end
    tick();
    drv_m1(1'b0, '0, '0, 3'd0, 1'b1);
    settle();
    chk("lock_hold_m0_gnt", 32'(a_m0_gnt), 32'd0);
    chk("lock_hold_s_we", 32'(a_s_we), 32'd0);
    tick();
    drv_m1(1'b1, 32'h510, '0, 3'd0, 1'b0);
    settle();
    chk("unlock_m0_gnt", 32'(a_m0_gnt), 32'd1);
    chk("unlock_m1_gnt", 32'(a_m1_gnt), 32'd0);
    tick();
    drv_m1(1'b0, '0, '0, 3'd0, 1'b1);
    settle();
    chk("free_lock_nogrant1", 32'(a_m0_gnt), 32'd1);
    tick();
    settle();
    chk("free_lock_nogrant2", 32'(a_m0_gnt), 32'd1);
    tick();
    idle();

    // ---------------- reset abandons LOCKED ----------------
    drv_m1(1'b1, 32'h520, '0, 3'd0, 1'b1);
    settle();
    chk("relock_m1_gnt", 32'(a_m1_gnt), 32'd1);
    tick();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drv_m0(1'b1, 32'h530, '0, 3'b001);
    drv_m1(1'b0, '0, '0, 3'd0, 1'b1);
    settle();
    chk("rst_unlock_m0_gnt", 32'(a_m0_gnt), 32'd1);
    tick();
    idle();

    // ---------------- reset mid-read ----------------
    drv_m1(1'b1, 32'h700, '0, 3'd0, 1'b0);
    settle();
    chk("rstrd_m1_gnt", 32'(b_m1_gnt), 32'd1);
    tick();
    rst = 1'b1;
    drv_m0(1'b1, 32'h704, 32'h5, 3'b011);
    drv_m1(1'b1, 32'h708, 32'h6, 3'b011, 1'b0);
    settle();
    chk("rstrd_m0_gnt", 32'(b_m0_gnt), 32'd0);
    chk("rstrd_m1_gnt_rst", 32'(b_m1_gnt), 32'd0);
    chk("rstrd_s_we", 32'(b_s_we), 32'd0);
    chk("rstrd_l2_m1_rvalid", 32'(b_m1_rvalid), 32'd0);
    chk("rstrd_l1_m1_rvalid", 32'(a_m1_rvalid), 32'd0);
    tick();
    rst = 1'b0;
    idle();
    settle();
    chk("rstrd_l2_after1", 32'(b_m1_rvalid), 32'd0);
    tick();
    settle();
    chk("rstrd_l2_after2", 32'(b_m1_rvalid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/localbus_arbiter.md
# localbus_arbiter

Shares the single data-memory port of `localbus` between two bus masters: master 0 is the `top_core` load/store port, master 1 is a secondary master (debug loader / DMA). It grants at most one single-beat transfer per cycle, steers address/write data/`we` to the slave, and routes each read result back to the issuing master through a latency-matched tag pipeline. It sits between `top_core`/secondary master and `U_localbus` in the board top.

## Interface

- `XLEN`, 32, data and address width.
- `RD_LAT`, 1, cycles from the slave accepting a read (`s_we==0`) to `s_qout` being valid; legal range 1..4.
- `STARVE_MAX`, 15, consecutive lost cycles before master 1 is forced to win; legal range 1..255.

Reset is synchronous and active-high, on one clock. Ports:

- `clk` in 1: sole clock, all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `m0_req` in 1: master 0 requests a transfer this cycle.
- `m0_addr` in XLEN: master 0 address.
- `m0_wdata` in XLEN: master 0 write data.
- `m0_we` in 3: master 0 write enable, `localbus` encoding; 0 means read.
- `m0_gnt` out 1: master 0 transfer accepted this cycle.
- `m0_rvalid` out 1: master 0 read data valid.
- `m0_rdata` out XLEN: master 0 read data.
- `m1_req`, `m1_addr`, `m1_wdata`, `m1_we`, `m1_gnt`, `m1_rvalid`, `m1_rdata`: same as the master 0 ports, for master 1.
- `m1_lock` in 1: master 1 requests exclusive ownership of the bus.
- `s_addr` out XLEN: address to the slave.
- `s_wdata` out XLEN: write data to the slave.
- `s_we` out 3: write enable to the slave.
- `s_qout` in XLEN: slave read data.

## Operation

- **Transfer rule**
  - A transfer completes in the cycle `mX_req && mX_gnt`.
  - A master holds its request and payload stable until it is granted.
  - At most one grant per cycle.
- **Slave drive**
  - With a grant, `s_addr/s_wdata/s_we` are a combinational mux of the granted master's payload.
  - With no grant, they are all 0, so no spurious write reaches the slave.
- **Arbitration state machine** (state register `own`):
  - `FREE`:
    - Master 0 wins on a tie.
    - Master 1 wins on a tie if `starve_cnt == STARVE_MAX`.
    - A lone requester always wins.
    - A master 1 grant with `m1_lock=1` moves to `LOCKED`.
  - `LOCKED`:
    - `m0_gnt` is held at 0.
    - Master 1 is granted whenever `m1_req`.
    - Return to `FREE` on any cycle with `m1_lock=0`; the grant decision in that cycle already uses `FREE` rules.
- **`starve_cnt`** (8-bit):
  - Increments, saturating at `STARVE_MAX`, in each cycle with `m1_req && !m1_gnt`.
  - Clears on `m1_gnt` or `!m1_req`.
- **Read return**
  - Tag pipeline of depth `RD_LAT`; each entry is `{valid, owner}`.
  - On a granted read (`we==0`), the pipeline is pushed with `{1, master}`. Writes push `{0, x}`.
  - `mX_rvalid` = pipeline tail valid, and tail owner == X.
  - `m0_rdata = m1_rdata = s_qout` (pass-through). Only `rvalid` discriminates between masters.
- **Back-to-back reads** from alternating masters return in issue order, one per cycle, with no bubbles.

## Timing

- Grant is combinational: `req` sampled in cycle N gives `gnt` in cycle N.
- Read data is returned in cycle N+`RD_LAT`.
- Writes take effect at the slave in cycle N.
- Reset values:
  - `own=FREE`, `starve_cnt=0`, tag pipeline all invalid.
  - `m0_gnt=m1_gnt=0` and `s_we=0` while `rst=1`, regardless of requests.
  - `mX_rvalid=0`.
- Reset mid-operation: reads in flight are dropped and no `rvalid` is produced for them. `LOCKED` is abandoned.
- `m1_lock` asserted with no `m1` grant has no effect in `FREE`.
- `STARVE_MAX` boundary: with both masters requesting continuously, master 1 is granted on its (`STARVE_MAX`+1)-th waiting cycle, then the counter clears.

## Configuration

- `LOCALBUS_ARB_RR_EN` defined:
  - `FREE`-state ties are resolved round-robin. A 1-bit `last` register toggles to the granted master, and the master not granted last wins the tie; `last` resets to 1, so master 0 wins the first tie.
  - `starve_cnt` is not built.
  - `LOCKED` is unchanged.
- Undefined: fixed priority to master 0 with starvation guard, as described above.

## Test plan

- **Single reads:** m0 read addr 0x100 with `s_qout`=0xDEADBEEF at N+1 -> `m0_rvalid`=1 at N+1 with rdata 0xDEADBEEF, `m1_rvalid`=0.
- **Tie:** both masters request in the same cycle, m0 write 0x10←0x1, m1 read 0x20 -> `m0_gnt`=1, `s_we`=m0_we, `m1_gnt`=1 next cycle, `m1_rvalid` one cycle later.
- **Starvation (default build):** m0 and m1 request continuously, `STARVE_MAX`=15 -> `m1_gnt` first on cycle 16 exactly, then m0 resumes.
- **Lock:** m1 granted with `m1_lock`=1, m1 then issues 3 more reads while m0 requests -> `m0_gnt`=0 throughout; it rises in the first cycle with `m1_lock`=0.
- **Reset mid-read:** m1 read granted, `rst`=1 next cycle (`RD_LAT`=2) -> no `m1_rvalid`, `s_we`=0 and both `gnt`=0 while in reset.
- **`LOCALBUS_ARB_RR_EN` build:** continuous requests from both masters -> grants alternate m0,m1,m0,m1 starting with m0.
